// File: rtl/fminmax_reduce.sv
`default_nettype none
//==============================================================================
//  Module      : fminmax_reduce
//  Description : Streaming min/max reduction over a vector of IEEE-754 single
//                precision words. Elements arrive on a valid/ready stream and
//                are folded into one registered winner. The winning value and
//                its element index are returned on a valid/ready result port.
//  Revision    : 1.0 - initial release
//==============================================================================
module fminmax_reduce #(
    parameter int unsigned LEN_W    = 8,
    parameter bit          MODE_MIN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    // request side
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             clear,
    output logic             busy,
    // element stream
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    // result stream
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [LEN_W-1:0] out_idx,
    output logic             out_empty
);

    localparam logic [LEN_W-1:0] c_len_one  = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0] c_len_zero = '0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q,   len_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic [LEN_W-1:0] idx_q,   idx_d;
    logic [31:0]      acc_q,   acc_d;
    logic             empty_q, empty_d;

    logic [31:0]      key_in;
    logic [31:0]      key_acc;
    logic             in_wins;
    logic             in_hs;
    logic             last_elem;

    // Map a float onto an unsigned key whose natural order is the
    // sign-magnitude total order: negatives are bit-inverted so a larger
    // magnitude sorts lower, positives get the top bit set so they sort
    // above every negative (this also places -0 just below +0).
    function automatic logic [31:0] order_key(input logic [31:0] f);
        return f[31] ? ~f : {1'b1, f[30:0]};
    endfunction

    assign key_in  = order_key(in_data);
    assign key_acc = order_key(acc_q);

    // Strict comparison only: on equal keys the accumulator is kept, so the
    // earliest index of a tied value is the one reported.
    generate
        if (MODE_MIN) begin : g_min
            assign in_wins = (key_in < key_acc);
        end else begin : g_max
            assign in_wins = (key_in > key_acc);
        end
    endgenerate

    // in_ready depends on state alone so it never combinationally loops
    // back through an upstream in_valid.
    assign in_ready  = (state_q == ST_ACCUM);
    assign in_hs     = in_valid && in_ready;
    assign last_elem = (count_q == (len_q - c_len_one));

    assign busy      = (state_q != ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign out_data  = acc_q;
    assign out_idx   = idx_q;
    assign out_empty = empty_q;

    // Next-state and datapath update; clear overrides every state.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        count_d = count_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        empty_d = empty_q;

        if (clear) begin
            state_d = ST_IDLE;
            count_d = c_len_zero;
            idx_d   = c_len_zero;
            acc_d   = 32'h0;
            empty_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        len_d   = len;
                        count_d = c_len_zero;
                        if (len == c_len_zero) begin
                            // Empty request: report a zero result at once.
                            state_d = ST_DONE;
                            empty_d = 1'b1;
                            acc_d   = 32'h0;
                            idx_d   = c_len_zero;
                        end else begin
                            state_d = ST_ACCUM;
                            empty_d = 1'b0;
                        end
                    end
                end

                ST_ACCUM: begin
                    if (in_hs) begin
                        count_d = count_q + c_len_one;
                        if (count_q == c_len_zero) begin
                            // First element seeds the accumulator.
                            acc_d = in_data;
                            idx_d = c_len_zero;
                        end else if (in_wins) begin
                            acc_d = in_data;
                            idx_d = count_q;
                        end
                        if (last_elem) begin
                            state_d = ST_DONE;
                        end
                    end
                end

                ST_DONE: begin
                    // Result held stable until the consumer takes it.
                    if (out_ready) begin
                        state_d = ST_IDLE;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            len_q   <= c_len_zero;
            count_q <= c_len_zero;
            idx_q   <= c_len_zero;
            acc_q   <= 32'h0;
            empty_q <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            empty_q <= empty_d;
        end
    end

endmodule
`default_nettype wire
